// File: rtl/rv_stim_pkg.sv
// rv_stim_pkg: shared encodings, class/state enums and class resolution for the stimulus generator
package rv_stim_pkg;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT = 7'b0100000;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   typedef enum logic [1:0] {CLS_R, CLS_I, CLS_LOAD} cls_t;
   typedef enum logic [1:0] {S_RESET, S_WARMUP, S_RUN, S_DONE} state_t;
   // Disabled classes step round-robin R->I->L->R; scanning downward lets the nearest enabled class win.
   function automatic cls_t resolve_cls(input logic [1:0] raw, input logic [2:0] mask);
      logic [1:0] base, k;
      cls_t c;
      base = raw == 2'd3 ? 2'd0 : raw;
      c = CLS_R;
      for (int i = 2; i >= 0; i--) begin
         k = 2'((int'(base) + i) % 3);
         if (mask[k]) c = cls_t'(k);
      end
      return c;
   endfunction
endpackage

// File: rtl/rv_stim_encode.sv
// rv_stim_encode: combinational LFSR state + class -> legal RV32I instruction word
module rv_stim_encode
   import rv_stim_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned DMEM_BYTES = 64
) (
   input  logic [29:0] s,
   input  cls_t        cls,
   output logic [31:0] word
);
   localparam logic [4:0] REG_MASK = 5'(NUM_REGS - 1);
   localparam logic [11:0] ADDR_MASK = 12'(DMEM_BYTES - 1);
   logic [4:0] rd, rs1, rs2;
   logic [2:0] f3, ld_f3;
   logic [11:0] imm, imm_i, imm_l;
   logic [6:0] f7;
   logic alt;
   always_comb begin
      rd = s[4:0] & REG_MASK;
      rs1 = s[9:5] & REG_MASK;
      rs2 = s[14:10] & REG_MASK;
      f3 = s[17:15];
      imm = s[29:18];
      alt = s[29];
      f7 = alt && (f3 == 3'd0 || f3 == 3'd5) ? F7_ALT : F7_ZERO;
      imm_i = f3 == 3'd1 ? {F7_ZERO, imm[4:0]} : f3 == 3'd5 ? {alt ? F7_ALT : F7_ZERO, imm[4:0]} : imm;
      // Loads are naturally aligned: LW clears imm[1:0], LH clears imm[0].
      ld_f3 = s[16] ? (s[15] ? 3'b001 : 3'b010) : (s[15] ? 3'b100 : 3'b000);
      imm_l = imm & ADDR_MASK & (s[16] ? (s[15] ? 12'hffe : 12'hffc) : 12'hfff);
      word = cls == CLS_R ? {f7, rs2, rs1, f3, rd, OP_R}
           : cls == CLS_I ? {imm_i, rs1, f3, rd, OP_I}
           : {imm_l, 5'd0, ld_f3, rd, OP_LOAD};
   end
endmodule

// File: rtl/rv_stim_instr_gen.sv
// rv_stim_instr_gen: seedable pseudo-random RV32I instruction stream with warm-up NOPs,
// valid/ready handshake and an optional instruction budget.
module rv_stim_instr_gen
   import rv_stim_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h0000_0070,
   parameter int unsigned NUM_REGS = 32,
   parameter logic [2:0] MODE_MASK = 3'b111,
   parameter int unsigned DMEM_BYTES = 64,
   parameter int unsigned WARMUP_NOPS = 2,
   parameter int unsigned INSTR_COUNT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_ready,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic        done,
   output logic [31:0] instr_count
);
   localparam logic [31:0] SEED_INIT = SEED == 32'd0 ? 32'h1 : SEED;
   state_t state, nxt_state;
   logic [31:0] lfsr, nxt_lfsr, warm_cnt, enc_word;
   logic acc, adv;
   cls_t cls;
   assign acc = instr_valid && instr_ready;
   assign adv = acc && (state == S_WARMUP || state == S_RUN);
   assign cls = resolve_cls(nxt_lfsr[31:30], MODE_MASK);
   always_comb begin
      nxt_lfsr = adv ? {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'd0) : lfsr;
      nxt_state = state;
      if (state == S_RESET) nxt_state = WARMUP_NOPS == 0 ? S_RUN : S_WARMUP;
      else if (acc && state == S_WARMUP && warm_cnt == WARMUP_NOPS - 1) nxt_state = S_RUN;
      else if (acc && state == S_RUN && INSTR_COUNT != 0 && instr_count == INSTR_COUNT - 1) nxt_state = S_DONE;
   end
   // The word is encoded from the next LFSR state so it is registered alongside the state change.
   rv_stim_encode #(.NUM_REGS(NUM_REGS), .DMEM_BYTES(DMEM_BYTES)) u_encode (
      .s(nxt_lfsr[29:0]),
      .cls(cls),
      .word(enc_word)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_RESET;
         lfsr <= SEED_INIT;
         warm_cnt <= 32'd0;
         instr <= NOP_INSTR;
         instr_valid <= 1'b0;
         done <= 1'b0;
         instr_count <= 32'd0;
      end else begin
         state <= nxt_state;
         lfsr <= nxt_lfsr;
         instr_valid <= 1'b1;
         instr <= nxt_state == S_RUN && MODE_MASK != 3'b000 ? enc_word : NOP_INSTR;
         done <= nxt_state == S_DONE;
         if (acc && state == S_WARMUP) warm_cnt <= warm_cnt + 32'd1;
         if (acc && state == S_RUN && instr_count != 32'hffff_ffff) instr_count <= instr_count + 32'd1;
      end
   end
endmodule

// File: tb/tb_rv_stim_instr_gen.sv
// tb_rv_stim_instr_gen: scoreboard bench for rv_stim_instr_gen across several parameter sets
module tb_rv_stim_instr_gen;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] SEED0 = 32'h0000_0070;
   logic clk = 1'b0, reset = 1'b1, reset2 = 1'b1, rdy0 = 1'b1, rdy = 1'b1;
   logic v0, v1, v2, v3, v4, dn0, dn1, dn2, dn3, dn4;
   logic [31:0] i0, i1, i2, i3, i4, c0, c1, c2, c3, c4;
   logic [31:0] q[$];
   logic [31:0] m0, m1 = 32'h1234_5678, m2 = 32'hdead_beef, m3 = 32'h0bad_cafe, m4 = 32'h1;
   logic [31:0] hand[4] = '{32'h0000_0733, 32'h0000_03b3, 32'h0080_0003, 32'h0040_0013};
   int checks = 0, errors = 0, n1 = 0, n2 = 0, n3 = 0, k4 = 0;
   always #5 clk = ~clk;

   rv_stim_instr_gen #(.SEED(SEED0), .NUM_REGS(32), .MODE_MASK(3'b111), .DMEM_BYTES(64), .WARMUP_NOPS(3), .INSTR_COUNT(0)) u0 (
      .clk(clk), .reset(reset), .instr_ready(rdy0), .instr_valid(v0), .instr(i0), .done(dn0), .instr_count(c0));
   rv_stim_instr_gen #(.SEED(32'h1234_5678), .NUM_REGS(32), .MODE_MASK(3'b001), .DMEM_BYTES(64), .WARMUP_NOPS(0), .INSTR_COUNT(0)) u1 (
      .clk(clk), .reset(reset2), .instr_ready(rdy), .instr_valid(v1), .instr(i1), .done(dn1), .instr_count(c1));
   rv_stim_instr_gen #(.SEED(32'hdead_beef), .NUM_REGS(32), .MODE_MASK(3'b010), .DMEM_BYTES(64), .WARMUP_NOPS(0), .INSTR_COUNT(0)) u2 (
      .clk(clk), .reset(reset2), .instr_ready(rdy), .instr_valid(v2), .instr(i2), .done(dn2), .instr_count(c2));
   rv_stim_instr_gen #(.SEED(32'h0bad_cafe), .NUM_REGS(4), .MODE_MASK(3'b100), .DMEM_BYTES(64), .WARMUP_NOPS(0), .INSTR_COUNT(0)) u3 (
      .clk(clk), .reset(reset2), .instr_ready(rdy), .instr_valid(v3), .instr(i3), .done(dn3), .instr_count(c3));
   rv_stim_instr_gen #(.SEED(32'h0), .NUM_REGS(32), .MODE_MASK(3'b111), .DMEM_BYTES(64), .WARMUP_NOPS(2), .INSTR_COUNT(10)) u4 (
      .clk(clk), .reset(reset2), .instr_ready(rdy), .instr_valid(v4), .instr(i4), .done(dn4), .instr_count(c4));

   function automatic logic [31:0] step(input logic [31:0] s);
      return s[0] ? (s >> 1) ^ 32'h8020_0003 : s >> 1;
   endfunction

   function automatic logic [31:0] gold(input logic [31:0] s, input logic [2:0] mask, input int nregs);
      logic [4:0] rm, rd, rs1, rs2;
      logic [2:0] f3, lf3;
      logic [11:0] imm, im;
      logic [6:0] hi;
      int c, sel;
      if (mask == 3'b000) return NOP;
      rm = 5'(nregs - 1);
      rd = s[4:0] & rm;
      rs1 = s[9:5] & rm;
      rs2 = s[14:10] & rm;
      f3 = s[17:15];
      imm = s[29:18];
      c = int'(s[31:30]) % 3;
      sel = -1;
      for (int i = 0; i < 3; i++) if (sel < 0 && mask[(c + i) % 3]) sel = (c + i) % 3;
      case (sel)
         0: begin
            hi = (s[29] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
            return {hi, rs2, rs1, f3, rd, 7'h33};
         end
         1: begin
            if (f3 == 3'd1) imm[11:5] = 7'h00;
            else if (f3 == 3'd5) imm[11:5] = s[29] ? 7'h20 : 7'h00;
            return {imm, rs1, f3, rd, 7'h13};
         end
         default: begin
            im = imm & 12'd63;
            case (s[16:15])
               2'd0: lf3 = 3'd0;
               2'd1: lf3 = 3'd4;
               2'd2: begin lf3 = 3'd2; im[1:0] = 2'b00; end
               default: begin lf3 = 3'd1; im[0] = 1'b0; end
            endcase
            return {im, 5'd0, lf3, rd, 7'h03};
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_ok(input string name, input logic ok, input logic [31:0] act);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL %s: got %h which breaks the required property", name, act);
      end
   endtask

   task automatic push_gold(input int n);
      for (int i = 0; i < n; i++) begin
         q.push_back(gold(m0, 3'b111, 32));
         m0 = step(m0);
      end
   endtask

   task automatic push_hand(input int lo, input int hi_idx);
      for (int i = lo; i <= hi_idx; i++) begin
         q.push_back(hand[i]);
         m0 = step(m0);
      end
   endtask

   task automatic push_warm();
      for (int i = 0; i < 3; i++) begin
         q.push_back(NOP);
         m0 = step(m0);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk_ok(name, 1'b0, q.size());
         q.delete();
      end
      #1 rdy0 = 1'b0;
   endtask

   // u0 scoreboard: every accepted beat must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && v0 && rdy0) begin
         if (q.size() == 0) chk_ok("u0_unexpected_beat", 1'b0, i0);
         else chk("u0_word", i0, q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (!reset2 && v1 && rdy) begin
         chk("u1_word", i1, gold(m1, 3'b001, 32));
         chk_ok("u1_rtype", i1[6:0] == 7'h33 && (i1[31:25] == 7'h00 || (i1[31:25] == 7'h20 && (i1[14:12] == 3'd0 || i1[14:12] == 3'd5))), i1);
         m1 = step(m1);
         n1++;
      end
      if (!reset2 && v2 && rdy) begin
         chk("u2_word", i2, gold(m2, 3'b010, 32));
         chk_ok("u2_itype", i2[6:0] == 7'h13 && (i2[14:12] != 3'd1 || i2[31:25] == 7'h00)
                && (i2[14:12] != 3'd5 || i2[31:25] == 7'h00 || i2[31:25] == 7'h20), i2);
         m2 = step(m2);
         n2++;
      end
      if (!reset2 && v3 && rdy) begin
         chk("u3_word", i3, gold(m3, 3'b100, 4));
         chk_ok("u3_load", i3[6:0] == 7'h03 && i3[19:15] == 5'd0 && i3[11:7] < 5'd4 && i3[31:20] < 12'd64
                && (i3[14:12] == 3'd0 || i3[14:12] == 3'd1 || i3[14:12] == 3'd2 || i3[14:12] == 3'd4)
                && !(i3[14:12] == 3'd2 && i3[21:20] != 2'b00) && !(i3[14:12] == 3'd1 && i3[20]), i3);
         m3 = step(m3);
         n3++;
      end
      if (!reset2 && v4 && rdy) begin
         if (k4 < 2) chk("u4_warm", i4, NOP);
         else if (k4 < 12) begin
            chk("u4_word", i4, gold(m4, 3'b111, 32));
            chk("u4_count", c4, 32'(k4 - 2));
         end else begin
            chk("u4_done_nop", i4, NOP);
            chk("u4_count_frozen", c4, 32'd10);
         end
         chk("u4_done", {31'd0, dn4}, {31'd0, k4 >= 12});
         if (k4 < 12) m4 = step(m4);
         k4++;
      end
   end

   initial begin
      m0 = SEED0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_valid", {31'd0, v0}, 32'd0);
         chk("rst_instr", i0, NOP);
         chk("rst_count", c0, 32'd0);
         chk("rst_done", {31'd0, dn0}, 32'd0);
         chk("rst_valid_u4", {31'd0, v4}, 32'd0);
      end
      push_warm();
      push_hand(0, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      reset2 = 1'b0;
      drain("u0_drain_first");
      @(negedge clk);
      chk("u0_count_beat4", c0, 32'd1);
      chk("u0_lfsr_beat4", u0.lfsr, m0);
      push_hand(1, 3);
      @(posedge clk);
      #1 rdy0 = 1'b1;
      drain("u0_drain_hand");
      // Backpressure window: word, count and LFSR must hold for five cycles.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_instr", i0, gold(m0, 3'b111, 32));
         chk("bp_count", c0, 32'd4);
         chk("bp_lfsr", u0.lfsr, m0);
      end
      push_gold(50);
      @(posedge clk);
      #1 rdy0 = 1'b1;
      drain("u0_drain_run");
      @(negedge clk);
      chk("u0_count_54", c0, 32'd54);
      push_gold(30);
      @(posedge clk);
      #1 rdy0 = 1'b1;
      for (int n = 0; n < 500 && q.size() > 15; n++) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 q.delete();
      m0 = SEED0;
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, v0}, 32'd0);
      chk("mid_rst_instr", i0, NOP);
      chk("mid_rst_count", c0, 32'd0);
      chk("mid_rst_lfsr", u0.lfsr, SEED0);
      push_warm();
      push_hand(0, 3);
      push_gold(46);
      @(posedge clk);
      #1 reset = 1'b0;
      drain("u0_drain_replay");
      @(negedge clk);
      chk("u0_count_replay", c0, 32'd50);
      repeat (2000) @(posedge clk);
      @(negedge clk);
      chk_ok("u1_beats", n1 >= 2000, n1);
      chk_ok("u2_beats", n2 >= 2000, n2);
      chk_ok("u3_beats", n3 >= 2000, n3);
      chk_ok("u4_beats", k4 >= 20, k4);
      chk("u4_done_final", {31'd0, dn4}, 32'd1);
      chk("u1_count_final", c1, n1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
